// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// The UART_TX_ARB_PKT_LOCK_EN build option is consumed by uart_tx_arbiter.
package uart_arb_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_e;

    // Index width for n requesters; never below one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: lowest valid index at or after the
// pointer wins, wrapping to the lowest valid index below it.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_Valid,
    input  logic [IDX_W-1:0]   i_Ptr,
    output logic [NUM_REQ-1:0] o_Onehot,
    output logic [IDX_W-1:0]   o_Index,
    output logic               o_Any
);

    logic [NUM_REQ-1:0] w_Hi;
    logic [NUM_REQ-1:0] w_Src;

    always_comb begin
        w_Hi = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_Hi[k] = i_Valid[k] && (k >= int'(i_Ptr));
        end
        // Requesters below the pointer only compete when none at/after it are valid.
        w_Src    = (|w_Hi) ? w_Hi : i_Valid;
        o_Onehot = '0;
        o_Index  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_Src[k]) begin
                o_Onehot    = '0;
                o_Onehot[k] = 1'b1;
                o_Index     = IDX_W'(k);
            end
        end
    end

    assign o_Any = |i_Valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX among NUM_REQ byte requesters.
// Define UART_TX_ARB_PKT_LOCK_EN to hold the grant until a packet's last byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                   i_Clock,
    input  logic                   i_Rst_L,
    input  logic [NUM_REQ-1:0]     i_Req_Valid,
    input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
    input  logic [NUM_REQ-1:0]     i_Req_Last,
    output logic [NUM_REQ-1:0]     o_Req_Ready,
    output logic [NUM_REQ-1:0]     o_Grant,
    output logic                   o_TX_DV,
    output logic [7:0]             o_TX_Byte,
    input  logic                   i_TX_Active,
    input  logic                   i_TX_Done,
    output logic                   o_Busy
);

    localparam int IDX_W = idx_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be 2..8");
    end

    arb_state_e          r_State, w_State_Next;
    logic [NUM_REQ-1:0]  r_Grant;
    logic [IDX_W-1:0]    r_Grant_Idx;
    logic [IDX_W-1:0]    r_Ptr;
    logic                r_TX_DV;
    logic [7:0]          r_TX_Byte;

    logic [NUM_REQ-1:0]  w_Eligible;
    logic [NUM_REQ-1:0]  w_Win_Onehot;
    logic [IDX_W-1:0]    w_Win_Idx;
    logic [IDX_W-1:0]    w_Ptr_Inc;
    logic                w_Win_Any;
    logic                w_Gnt_Valid;
    logic                w_Load_Grant;
    logic                w_Accept;
    logic                w_Drop;
    logic                w_Complete;
    logic                w_Ptr_Adv;

`ifdef UART_TX_ARB_PKT_LOCK_EN
    logic                r_Lock_Set;
    logic [IDX_W-1:0]    r_Lock_Idx;
    logic                r_Last;

    always_comb begin
        w_Eligible = i_Req_Valid;
        if (r_Lock_Set) begin
            w_Eligible             = '0;
            w_Eligible[r_Lock_Idx] = i_Req_Valid[r_Lock_Idx];
        end
    end

    // Lock is taken by a non-last byte and only released when the last byte completes.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Lock_Set <= 1'b0;
            r_Lock_Idx <= '0;
            r_Last     <= 1'b0;
        end else if (w_Accept) begin
            r_Last <= i_Req_Last[r_Grant_Idx];
            if (!i_Req_Last[r_Grant_Idx]) begin
                r_Lock_Set <= 1'b1;
                r_Lock_Idx <= r_Grant_Idx;
            end
        end else if (w_Complete && r_Last) begin
            r_Lock_Set <= 1'b0;
        end
    end

    assign w_Ptr_Adv = w_Complete && r_Last;
`else
    logic w_unused_last;

    assign w_Eligible    = i_Req_Valid;
    assign w_Ptr_Adv     = w_Complete;
    assign w_unused_last = ^i_Req_Last;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_Valid  (w_Eligible),
        .i_Ptr    (r_Ptr),
        .o_Onehot (w_Win_Onehot),
        .o_Index  (w_Win_Idx),
        .o_Any    (w_Win_Any)
    );

    assign w_Gnt_Valid = |(i_Req_Valid & r_Grant);
    assign w_Ptr_Inc   = (r_Grant_Idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_Grant_Idx + 1'b1;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State <= IDLE;
        end else begin
            r_State <= w_State_Next;
        end
    end

    always_comb begin
        w_State_Next = r_State;
        w_Load_Grant = 1'b0;
        w_Accept     = 1'b0;
        w_Drop       = 1'b0;
        w_Complete   = 1'b0;
        case (r_State)
            IDLE: begin
                if (!i_TX_Active && w_Win_Any) begin
                    w_Load_Grant = 1'b1;
                    w_State_Next = LAUNCH;
                end
            end
            LAUNCH: begin
                if (w_Gnt_Valid) begin
                    w_Accept     = 1'b1;
                    w_State_Next = WAIT_DONE;
                end else begin
                    w_Drop       = 1'b1;
                    w_State_Next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (i_TX_Done) begin
                    w_Complete   = 1'b1;
                    w_State_Next = IDLE;
                end
            end
            default: w_State_Next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Grant     <= '0;
            r_Grant_Idx <= '0;
            r_Ptr       <= '0;
            r_TX_DV     <= 1'b0;
            r_TX_Byte   <= 8'h00;
        end else begin
            r_TX_DV <= w_Accept;
            if (w_Load_Grant) begin
                r_Grant     <= w_Win_Onehot;
                r_Grant_Idx <= w_Win_Idx;
            end else if (w_Drop || w_Complete) begin
                r_Grant <= '0;
            end
            if (w_Accept) begin
                r_TX_Byte <= i_Req_Byte[{r_Grant_Idx, 3'b000} +: 8];
            end
            if (w_Ptr_Adv) begin
                r_Ptr <= w_Ptr_Inc;
            end
        end
    end

    assign o_Req_Ready = (r_State == LAUNCH) ? r_Grant : '0;
    assign o_Grant     = r_Grant;
    assign o_TX_DV     = r_TX_DV;
    assign o_TX_Byte   = r_TX_Byte;
    assign o_Busy      = (r_State != IDLE);

endmodule
